apb4_slave_mem: RTL and testbench

- Downstream completer for the APB3/APB4 bridge. It receives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT from the apb_top master path and returns PREADY/PRDATA/PSLVERR.
- It holds a small word-indexed register memory with a programmable wait-state count, byte strobes, range checking and a secure-region check.
- It is the slave that apb_top's master FSM drives; read data and error status propagate back to apb_rdata/PSLVERR.

---
 rtl/apb4_slave_mem_if.sv | 40 ++++
 rtl/apb4_slave_mem.sv | 211 +++++++++++++++++++++
 tb/tb_apb4_slave_mem.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_slave_mem_if.sv
// -----------------------------------------------------------------------------
// apb4_slave_mem_if
// APB3/APB4 completer-side bus bundle between the bridge master path and the
// register-memory slave.
//   PSEL     master->slave  slave select
//   PENABLE  master->slave  access phase
//   PWRITE   master->slave  1=write, 0=read
//   PADDR    master->slave  word index (ADDR_WIDTH bits, not a byte address)
//   PWDATA   master->slave  write data
//   PSTRB    master->slave  byte write enables
//   PPROT    master->slave  protection; bit 1 = non-secure
//   PREADY   slave->master  transfer completion
//   PRDATA   slave->master  read data
//   PSLVERR  slave->master  error response
// -----------------------------------------------------------------------------
interface apb4_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic                      PREADY;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb4_slave_mem.sv
// -----------------------------------------------------------------------------
// apb4_slave_mem
// APB completer holding a small word-indexed register memory. Every access
// phase is stretched by a fixed number of wait states, writes honour byte
// strobes, and out-of-range or non-secure-to-secure accesses complete with
// PSLVERR and have no side effect.
// Ports:
//   PCLK     in   clock, all state changes on the rising edge
//   PRESETn  in   asynchronous active-low reset (clears FSM, outputs, memory)
//   apb      slave modport of apb4_slave_mem_if (request in, response out)
// PREADY/PRDATA/PSLVERR are driven straight from flops.
// -----------------------------------------------------------------------------
module apb4_slave_mem #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 16,
    parameter int WAIT_STATES  = 2,
    parameter int SECURE_WORDS = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb4_slave_mem_if.slave   apb
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    // Compare width wide enough to hold both the full address and the
    // depth/secure limits, so every address bit takes part in the range check.
    localparam int CMP_W  = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

    localparam logic [CMP_W-1:0] DEPTH_C  = CMP_W'(MEM_DEPTH);
    localparam logic [CMP_W-1:0] SECURE_C = CMP_W'(SECURE_WORDS);
    localparam logic [3:0]       WAIT_LOAD_C =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Replace only the strobed bytes of the old word with the new data.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // FSM and wait counter
    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;

    // Transfer attributes captured at the setup phase
    logic                   write_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_W-1:0]      strb_q;
    logic                   err_q;

    // Registered response
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    logic                   capture_s;
    logic                   err_s;
    logic                   done_next_s;
    logic                   commit_s;
    logic [CMP_W-1:0]       addr_ext_s;
    logic                   unused_prot_s;

    // Only PPROT[1] (non-secure) matters to this completer.
    assign unused_prot_s = apb.PPROT[2] ^ apb.PPROT[0];

    // Error decision on the live setup-phase request; it is frozen into err_q
    // when the request is captured, so later bus changes cannot alter it.
    always_comb begin
        addr_ext_s = CMP_W'(apb.PADDR);
        err_s      = (addr_ext_s >= DEPTH_C) ||
                     ((SECURE_WORDS > 0) && (addr_ext_s < SECURE_C) && apb.PPROT[1]);
    end

    // Next-state logic for the transfer FSM and the wait-state counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    state_d   = ST_SETUP;
                    capture_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (apb.PENABLE) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD_C;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_WAIT: begin
                // Dropping PSEL or PENABLE here abandons the transfer.
                if (!apb.PSEL || !apb.PENABLE) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response computed one cycle ahead so PREADY/PRDATA/PSLVERR come from flops.
    // Memory writes commit at the end of DONE, so a read here sees every write
    // from earlier transfers.
    always_comb begin
        done_next_s = (state_d == ST_DONE);
        pready_d    = done_next_s;
        pslverr_d   = done_next_s && err_q;
        if (done_next_s && !err_q && !write_q) begin
            prdata_d = mem_q[idx_q];
        end else begin
            prdata_d = '0;
        end
        commit_s    = (state_q == ST_DONE) && write_q && !err_q;
    end

    // FSM state, counter and registered response
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Capture of the request during the setup phase
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (capture_s) begin
            write_q <= apb.PWRITE;
            // Low index bits are only ever used when err_q is clear, i.e. in range.
            idx_q   <= apb.PADDR[IDX_W-1:0];
            wdata_q <= apb.PWDATA;
            strb_q  <= apb.PSTRB;
            err_q   <= err_s;
        end
    end

    // Register memory: cleared by reset, byte-strobed write on the PREADY edge
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_s) begin
            mem_q[idx_q] <= merge_bytes(mem_q[idx_q], wdata_q, strb_q);
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb4_slave_mem
// Directed bench for apb4_slave_mem (WAIT_STATES=2, SECURE_WORDS=4). The driver
// pushes the expected response of each transfer into a queue; an independent
// monitor on the falling clock edge pops and compares whenever PREADY is high,
// and otherwise checks that PRDATA/PSLVERR are idle-zero.
// -----------------------------------------------------------------------------
module tb_apb4_slave_mem;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WS = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic PCLK;
    logic PRESETn;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    apb4_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb4_slave_mem #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_DEPTH   (16),
        .WAIT_STATES (WS),
        .SECURE_WORDS(4)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Monitor: compare responses against the scoreboard queue.
    initial begin
        exp_t e;
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge PCLK);
            if (apb.PREADY === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pready: got PRDATA=%08h PSLVERR=%b, required no PREADY pulse",
                             apb.PRDATA, apb.PSLVERR);
                end else begin
                    e = exp_q.pop_front();
                    if (apb.PRDATA !== e.rdata || apb.PSLVERR !== e.err) begin
                        n_fail++;
                        $display("FAIL response: got PRDATA=%08h PSLVERR=%b, required PRDATA=%08h PSLVERR=%b",
                                 apb.PRDATA, apb.PSLVERR, e.rdata, e.err);
                    end
                end
            end else begin
                n_tests++;
                if (apb.PRDATA !== 32'h0 || apb.PSLVERR !== 1'b0 || apb.PREADY !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs: got PREADY=%b PRDATA=%08h PSLVERR=%b, required 0/00000000/0",
                             apb.PREADY, apb.PRDATA, apb.PSLVERR);
                end
            end
        end
    end

    task automatic bus_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 32'h0;
        apb.PWDATA  = 32'h0;
        apb.PSTRB   = 4'h0;
        apb.PPROT   = 3'b000;
    endtask

    task automatic drive_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        apb.PSTRB   = strb;
        apb.PPROT   = prot;
    endtask

    // Full transfer; entered and left #1 after a rising edge, so consecutive
    // calls are back-to-back. Also checks the access-phase latency.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   cyc;
        bit   got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        drive_setup(wr, addr, wdata, strb, prot);
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge PCLK);
            if (apb.PREADY === 1'b1) begin
                got = 1'b1;
            end else begin
                @(posedge PCLK); #1;
                cyc++;
            end
        end
        n_tests++;
        if (!got || cyc != WS + 1) begin
            n_fail++;
            $display("FAIL latency: addr=%0d got %0d cycles (seen=%b), required %0d",
                     addr, cyc, got, WS + 1);
        end
        @(posedge PCLK); #1;
        bus_idle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] prot, input logic exp_err);
        xfer(1'b1, addr, d, s, prot, 32'h0, exp_err);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] prot,
                      input logic [31:0] exp_d, input logic exp_err);
        xfer(1'b0, addr, 32'h0, 4'h0, prot, exp_d, exp_err);
    endtask

    initial begin
        PRESETn = 1'b0;
        bus_idle();
        repeat (3) @(posedge PCLK);
        #1;
        n_tests++;
        if (apb.PREADY !== 1'b0 || apb.PRDATA !== 32'h0 || apb.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%08h/%b, required 0/00000000/0",
                     apb.PREADY, apb.PRDATA, apb.PSLVERR);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Basic write then read back
        wr(32'd3, 32'h0000_0006, 4'hF, 3'b000, 1'b0);
        rd(32'd3, 3'b000, 32'h0000_0006, 1'b0);

        // Byte strobes: 0x5 updates bytes 0 and 2
        wr(32'd5, 32'hAABB_CCDD, 4'hF, 3'b000, 1'b0);
        wr(32'd5, 32'h1122_3344, 4'h5, 3'b000, 1'b0);
        rd(32'd5, 3'b000, 32'hAA22_CC44, 1'b0);

        // Range errors leave memory untouched; no aliasing of 19/22 onto 3/6
        wr(32'd6, 32'h0000_0066, 4'hF, 3'b000, 1'b0);
        wr(32'd22, 32'd35, 4'hF, 3'b000, 1'b1);
        rd(32'd500, 3'b000, 32'h0, 1'b1);
        rd(32'd19, 3'b000, 32'h0, 1'b1);
        wr(32'h8000_0006, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b1);
        rd(32'd6, 3'b000, 32'h0000_0066, 1'b0);
        rd(32'd3, 3'b000, 32'h0000_0006, 1'b0);

        // PSTRB=0 is a legal no-op
        wr(32'd6, 32'h1234_5678, 4'h0, 3'b000, 1'b0);
        rd(32'd6, 3'b000, 32'h0000_0066, 1'b0);

        // Last valid index
        wr(32'd15, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b0);
        rd(32'd15, 3'b000, 32'hCAFE_F00D, 1'b0);

        // Secure region (words 0..3)
        wr(32'd2, 32'h0000_1234, 4'hF, 3'b000, 1'b0);
        rd(32'd2, 3'b010, 32'h0, 1'b1);
        wr(32'd2, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1);
        rd(32'd2, 3'b000, 32'h0000_1234, 1'b0);
        rd(32'd4, 3'b010, 32'h0, 1'b0);

        // Reset during WAIT of the index-7 write
        for (int i = 0; i < 7; i++) begin
            wr(i, 2 * i, 4'hF, 3'b000, 1'b0);
        end
        drive_setup(1'b1, 32'd7, 32'd14, 4'hF, 3'b000);
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        n_tests++;
        if (apb.PREADY !== 1'b0 || apb.PRDATA !== 32'h0 || apb.PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got %b/%08h/%b, required 0/00000000/0",
                     apb.PREADY, apb.PRDATA, apb.PSLVERR);
        end
        bus_idle();
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        for (int i = 0; i < 8; i++) begin
            rd(i, 3'b000, 32'h0, 1'b0);
        end

        // PSEL dropped during WAIT of a write to index 1: no pulse, no write
        drive_setup(1'b1, 32'd1, 32'hDEAD_0001, 4'hF, 3'b000);
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus_idle();
        repeat (6) @(posedge PCLK);
        #1;
        rd(32'd1, 3'b000, 32'h0, 1'b0);
        wr(32'd1, 32'h0000_0055, 4'hF, 3'b000, 1'b0);
        rd(32'd1, 3'b000, 32'h0000_0055, 1'b0);

        repeat (3) @(posedge PCLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
